// File: rtl/shifter_arb.sv
// shifter_arb: two clients share one 4-bit one-position left shifter, round-robin on contention.
// Latency: req sampled in IDLE -> gnt next cycle -> y_valid the cycle after; RESP holds y until y_ready, no grants meanwhile.

module shifter_arb_shift (
    input  logic [3:0] w_i,
    input  logic       sel_i,
    output logic [4:0] y_o
);
    assign y_o = sel_i ? {w_i, 1'b0} : {1'b0, w_i};
endmodule

module shifter_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] w0,
    input  logic       shift0,
    input  logic       req1,
    input  logic [3:0] w1,
    input  logic       shift1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [4:0] y,
    output logic       y_id,
    output logic       y_valid,
    input  logic       y_ready,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q;
    logic [3:0] op_w_q;
    logic       op_shift_q;
    logic       op_id_q;
    logic       last_q;
    logic [4:0] y_q;
    logic       y_id_q;
    logic       y_valid_q;
    logic       gnt0_q;
    logic       gnt1_q;

    logic       win_d;
    logic [3:0] win_w_d;
    logic       win_shift_d;
    logic [4:0] shift_res;

    // On contention the requester not served last wins; a lone request always wins.
    always_comb begin
        win_d       = (req0 && req1) ? ~last_q : req1;
        win_w_d     = win_d ? w1 : w0;
        win_shift_d = win_d ? shift1 : shift0;
    end

    shifter_arb_shift u_shift (
        .w_i   (op_w_q),
        .sel_i (op_shift_q),
        .y_o   (shift_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_w_q     <= 4'b0;
            op_shift_q <= 1'b0;
            op_id_q    <= 1'b0;
            last_q     <= 1'b1;
            y_q        <= 5'b0;
            y_id_q     <= 1'b0;
            y_valid_q  <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        op_w_q     <= win_w_d;
                        op_shift_q <= win_shift_d;
                        op_id_q    <= win_d;
                        last_q     <= win_d;
                        gnt0_q     <= ~win_d;
                        gnt1_q     <= win_d;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    y_q       <= shift_res;
                    y_id_q    <= op_id_q;
                    y_valid_q <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign y       = y_q;
    assign y_id    = y_id_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_shifter_arb.sv
// Bench for shifter_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_shifter_arb;
    logic       clk = 1'b0;
    logic       rst, req0, shift0, req1, shift1, y_ready;
    logic [3:0] w0, w1;
    logic       gnt0, gnt1, y_id, y_valid, busy;
    logic [4:0] y;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    shifter_arb dut (
        .clk(clk), .rst(rst),
        .req0(req0), .w0(w0), .shift0(shift0),
        .req1(req1), .w1(w1), .shift1(shift1),
        .gnt0(gnt0), .gnt1(gnt1),
        .y(y), .y_id(y_id), .y_valid(y_valid), .y_ready(y_ready),
        .busy(busy)
    );

    // Shift-by-one is doubling; pass-through is the zero-extended word.
    function automatic logic [4:0] ref_shift(input logic [3:0] w, input logic s);
        return s ? 5'(w) * 5'd2 : 5'(w);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; w0 = 4'b0; w1 = 4'b0;
        shift0 = 1'b0; shift1 = 1'b0; y_ready = 1'b0;
        step; step;
        n_cmp++; if (y !== 5'b0)      begin n_err++; $display("FAIL reset_y got=%b exp=00000", y); end
        n_cmp++; if (y_id !== 1'b0)   begin n_err++; $display("FAIL reset_y_id got=%b exp=0", y_id); end
        n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
        n_cmp++; if ({gnt1, gnt0} !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", {gnt1, gnt0}); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; y_ready = 1'b1;
        step;
        n_cmp++; if ({gnt1, gnt0, busy} !== 3'b000) begin n_err++; $display("FAIL idle_no_req got=%b exp=000", {gnt1, gnt0, busy}); end
    endtask

    task automatic test_single;
        req0 = 1'b1; w0 = 4'b1011; shift0 = 1'b1; y_ready = 1'b1;
        step;
        n_cmp++; if ({gnt1, gnt0, busy} !== 3'b011) begin n_err++; $display("FAIL single_gnt got=%b exp=011", {gnt1, gnt0, busy}); end
        req0 = 1'b0;
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b00) begin n_err++; $display("FAIL single_gnt_pulse got=%b exp=00", {gnt1, gnt0}); end
        n_cmp++; if ({y_valid, y_id, y} !== {1'b1, 1'b0, 5'b10110}) begin n_err++; $display("FAIL single_result got=%b/%b/%b exp=1/0/10110", y_valid, y_id, y); end
        step;
        n_cmp++; if ({y_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_retire got=%b exp=00", {y_valid, busy}); end
    endtask

    task automatic test_pass;
        req1 = 1'b1; w1 = 4'b1011; shift1 = 1'b0;
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b10) begin n_err++; $display("FAIL pass_gnt got=%b exp=10", {gnt1, gnt0}); end
        req1 = 1'b0;
        step;
        n_cmp++; if ({y_valid, y_id, y} !== {1'b1, 1'b1, 5'b01011}) begin n_err++; $display("FAIL pass_result got=%b/%b/%b exp=1/1/01011", y_valid, y_id, y); end
        step;
        req1 = 1'b1; w1 = 4'b1111; shift1 = 1'b1;
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b10) begin n_err++; $display("FAIL full_gnt got=%b exp=10", {gnt1, gnt0}); end
        req1 = 1'b0;
        step;
        n_cmp++; if ({y_valid, y_id, y} !== {1'b1, 1'b1, 5'b11110}) begin n_err++; $display("FAIL full_result got=%b/%b/%b exp=1/1/11110", y_valid, y_id, y); end
        step;
    endtask

    task automatic test_contention;
        logic exp_id;
        int   waited;
        rst = 1'b1; y_ready = 1'b1;
        req0 = 1'b1; w0 = 4'b0011; shift0 = 1'b0;
        req1 = 1'b1; w1 = 4'b0101; shift1 = 1'b1;
        step;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            waited = 0;
            while (!(gnt0 || gnt1) && waited < 6) begin step; waited++; end
            n_cmp++; if (waited >= 6) begin n_err++; $display("FAIL contention_timeout op=%0d waited=%0d limit=6", k, waited); end
            n_cmp++; if (gnt0 && gnt1) begin n_err++; $display("FAIL contention_overlap op=%0d got=11 exp=one-hot", k); end
            n_cmp++; if ({gnt1, gnt0} !== (exp_id ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contention_order op=%0d got=%b exp_id=%0d", k, {gnt1, gnt0}, exp_id); end
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            step;
            n_cmp++; if ({y_valid, y_id} !== {1'b1, exp_id}) begin n_err++; $display("FAIL contention_id op=%0d got=%b%b exp=1%b", k, y_valid, y_id, exp_id); end
            n_cmp++; if (y !== (exp_id ? ref_shift(w1, shift1) : ref_shift(w0, shift0))) begin n_err++; $display("FAIL contention_y op=%0d got=%b", k, y); end
            step;
        end
    endtask

    task automatic test_backpressure;
        logic [4:0] y_hold;
        y_ready = 1'b0;
        req0 = 1'b1; w0 = 4'b0110; shift0 = 1'b1;
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b01) begin n_err++; $display("FAIL bp_gnt0 got=%b exp=01", {gnt1, gnt0}); end
        req0 = 1'b0; req1 = 1'b1; w1 = 4'b1001; shift1 = 1'b0;
        step;
        y_hold = 5'b01100;
        n_cmp++; if ({y_valid, y_id, y} !== {1'b1, 1'b0, y_hold}) begin n_err++; $display("FAIL bp_result got=%b/%b/%b exp=1/0/01100", y_valid, y_id, y); end
        for (int c = 0; c < 5; c++) begin
            step;
            n_cmp++;
            if ({y_valid, y_id, y, busy, gnt1, gnt0} !== {1'b1, 1'b0, y_hold, 1'b1, 2'b00}) begin
                n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%b busy=%b gnt=%b%b", c, y_valid, y_id, y, busy, gnt1, gnt0);
            end
        end
        y_ready = 1'b1;
        step;
        n_cmp++; if ({y_valid, busy, gnt1, gnt0} !== 4'b0000) begin n_err++; $display("FAIL bp_retire got=%b exp=0000", {y_valid, busy, gnt1, gnt0}); end
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b10) begin n_err++; $display("FAIL bp_gnt1 got=%b exp=10", {gnt1, gnt0}); end
        req1 = 1'b0;
        step;
        n_cmp++; if ({y_valid, y_id, y} !== {1'b1, 1'b1, 5'b01001}) begin n_err++; $display("FAIL bp_result1 got=%b/%b/%b exp=1/1/01001", y_valid, y_id, y); end
        step;
    endtask

    task automatic test_reset_mid;
        y_ready = 1'b1;
        req0 = 1'b1; w0 = 4'b1010; shift0 = 1'b0;
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b01) begin n_err++; $display("FAIL rmid_gnt got=%b exp=01", {gnt1, gnt0}); end
        rst = 1'b1; req1 = 1'b1; w1 = 4'b0111; shift1 = 1'b1;
        step;
        n_cmp++; if ({y_valid, y, gnt1, gnt0, busy} !== 9'b0) begin n_err++; $display("FAIL rmid_flush got=%b/%b gnt=%b%b busy=%b exp=all 0", y_valid, y, gnt1, gnt0, busy); end
        rst = 1'b0;
        step;
        n_cmp++; if ({gnt1, gnt0} !== 2'b01) begin n_err++; $display("FAIL rmid_regrant got=%b exp=01", {gnt1, gnt0}); end
        req0 = 1'b0; req1 = 1'b0;
        step;
        n_cmp++; if ({y_valid, y_id, y} !== {1'b1, 1'b0, 5'b01010}) begin n_err++; $display("FAIL rmid_result got=%b/%b/%b exp=1/0/01010", y_valid, y_id, y); end
        step;
    endtask

    task automatic test_random;
        logic       m_last, m_out, m_valid, win, acc;
        logic [1:0] m_gnt, nxt_gnt;
        logic [5:0] q[$];
        int         gcnt, rcnt;
        gcnt = 0; rcnt = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; y_ready = 1'b1;
        step;
        rst = 1'b0;
        m_last = 1'b1; m_out = 1'b0; m_valid = 1'b0; m_gnt = 2'b00;
        for (int c = 0; c < 600; c++) begin
            if (c < 560) begin
                req0 = 1'($urandom); req1 = 1'($urandom);
                w0 = 4'($urandom); w1 = 4'($urandom);
                shift0 = 1'($urandom); shift1 = 1'($urandom);
                y_ready = ($urandom % 4) != 0;
            end else begin
                req0 = 1'b0; req1 = 1'b0; y_ready = 1'b1;
            end
            if (y_valid && y_ready) rcnt++;
            acc = m_valid && y_ready;
            nxt_gnt = 2'b00;
            if (!m_out && (req0 || req1)) begin
                win = (req0 && req1) ? ~m_last : req1;
                m_last = win; m_out = 1'b1;
                nxt_gnt = win ? 2'b10 : 2'b01;
                q.push_back({win, win ? ref_shift(w1, shift1) : ref_shift(w0, shift0)});
            end
            if (m_gnt != 2'b00) m_valid = 1'b1;
            if (acc) begin
                m_valid = 1'b0; m_out = 1'b0;
                if (q.size() > 0) void'(q.pop_front());
            end
            m_gnt = nxt_gnt;
            step;
            if (gnt0 || gnt1) gcnt++;
            n_cmp++; if ({gnt1, gnt0} !== m_gnt) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {gnt1, gnt0}, m_gnt); end
            n_cmp++; if ({y_valid, busy} !== {m_valid, m_out}) begin n_err++; $display("FAIL rnd_valid_busy cyc=%0d got=%b exp=%b", c, {y_valid, busy}, {m_valid, m_out}); end
            if (m_valid && q.size() > 0) begin
                n_cmp++; if ({y_id, y} !== q[0]) begin n_err++; $display("FAIL rnd_result cyc=%0d got=%b exp=%b", c, {y_id, y}, q[0]); end
            end
        end
        n_cmp++; if (gcnt !== rcnt) begin n_err++; $display("FAIL rnd_gnt_vs_results grants=%0d results=%0d", gcnt, rcnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_pass;
        test_contention;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/shifter_arb.md
# shifter_arb

Two-requester arbiter and sequencer for the shared 4-bit one-position left shifter (4-bit word in, 5-bit result out, `shift` selects shifted or pass-through). The block lets two client blocks share one shifter datapath. It arbitrates round-robin, registers the winner's operands, drives the internal shifter instance, and returns a registered, tagged result with a valid/ready handshake. It sits between the clients and the shifter; clients never drive the shifter directly.

## Interface
Parameters: none (widths fixed by the shifter: 4-bit operand, 5-bit result).

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 wants an operation; held with w0/shift0 until gnt0
- w0  in  4  requester 0 operand
- shift0  in  1  requester 0 mode: 1 = shift left by one (LSB filled with 0), 0 = pass-through (MSB of result = 0)
- req1, w1, shift1  in  1/4/1  same meaning for requester 1
- gnt0  out  1  one-cycle pulse: requester 0 operands accepted
- gnt1  out  1  one-cycle pulse: requester 1 operands accepted
- y  out  5  result, stable while y_valid = 1
- y_id  out  1  requester that owns y (0 or 1)
- y_valid  out  1  result available
- y_ready  in  1  consumer accepts y when y_valid && y_ready at the clock edge
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, EXEC, RESP. Encoding is free.
- Registers: op_w[3:0], op_shift, op_id, last (last-served id), y, y_id, y_valid, gnt0, gnt1.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose a winner, latch its w/shift/id into op regs, set the matching gnt for the next cycle, go to EXEC.
- Arbitration:
  - Only req0 set: choose 0. Only req1 set: choose 1.
  - Both set: choose `~last`.
  - `last` updates to the winner at the grant edge.
- EXEC:
  - gnt pulse is high in this state only.
  - The shifter instance sees sel = op_shift, w = op_w.
  - At the edge: y ← shifter output, y_id ← op_id, y_valid ← 1, go to RESP.
- RESP:
  - y, y_id and y_valid hold.
  - y_ready = 1 at the edge: y_valid ← 0, go to IDLE.
  - y_ready = 0: stay in RESP indefinitely. No new grants while here.
- Arithmetic:
  - shift = 1: y = {w, 1'b0}.
  - shift = 0: y = {1'b0, w}.
  - No overflow is possible; the result is always 5 bits.
- Requesters may drop req the cycle after seeing gnt. A req still held after its gnt is treated as a new request in the next IDLE.
- Request/data changes while not granted are allowed. The block samples only in IDLE.

## Timing
- Reset values: state = IDLE, y = 5'b0, y_id = 0, y_valid = 0, gnt0 = gnt1 = 0, busy = 0, op regs = 0, last = 1 (requester 0 wins the first contention).
- Request sampled in IDLE at edge E0 → gnt high during cycle E0..E1 (EXEC).
- y_valid rises at E1 and is visible in the cycle after the gnt pulse. Latency from sampled req to y_valid is 2 edges.
- Best-case throughput: one operation per 3 cycles (IDLE, EXEC, RESP with y_ready = 1).
- y_ready high in a cycle where y_valid = 0 has no effect.
- rst = 1 at any edge, including during EXEC or RESP: the in-flight operation is discarded with no result and no gnt. All outputs take their reset values at that edge.
- A request still held through reset is re-arbitrated starting at the first IDLE cycle after rst falls.
- gnt0 and gnt1 are never high together. Exactly one gnt pulse occurs per result.

## Test plan
- Single op: req0 = 1, w0 = 4'b1011, shift0 = 1 → gnt0 pulses 1 cycle after sampling. One cycle later y = 5'b10110, y_id = 0, y_valid = 1. With y_ready = 1, y_valid drops after one cycle.
- Pass-through and full word: req1, w1 = 4'b1011, shift1 = 0 → y = 5'b01011, y_id = 1. Then w1 = 4'b1111, shift1 = 1 → y = 5'b11110.
- Contention: req0 and req1 both held continuously from reset → grant order 0, 1, 0, 1. y_id alternates. No gnt overlap.
- Back-pressure: y_ready = 0 for 5 cycles in RESP → y, y_id and y_valid stable, busy = 1, no gnt while req1 is pending. y_ready = 1 → result retires, then gnt1 issues 1 cycle after returning to IDLE.
- Reset mid-op: assert rst during the EXEC cycle → next cycle y_valid = 0, y = 0, gnt = 0, busy = 0. The held req0 is regranted after rst deasserts, and requester 0 wins contention (last reset to 1).
- Scoreboard over random req, w, shift and y_ready traffic: each result equals the shift model for its y_id's operands. Count of gnt pulses equals count of accepted results.
